mem_port_arbiter: RTL and testbench

Single-port access scheduler in front of the byte-addressable data memory (4 KiB, func3-encoded load/store widths, read data combinational off the registered address path). Shares that one port between the instruction-fetch requester and the load/store requester of the RISC-V core. Grants at most one access per cycle, with data priority and a bounded-starvation guarantee for fetch. Rejects misaligned or illegal-width data accesses before they reach memory.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_align_chk.sv | 34 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the data-memory port arbiter:
//   - F3_* : RISC-V func3 load/store width codes understood by the memory
//   - resp_t : owner of the response phase one cycle after a grant
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2,
        RESP_ERR  = 2'd3
    } resp_t;

endpackage

// File: rtl/mem_align_chk.sv
// ---------------------------------------------------------------------------
// mem_align_chk
// Combinational legality check for a data-side memory access.
// Ports:
//   we      in  1  1 = store, 0 = load
//   func3   in  3  width code
//   addr_lo in  2  low two bits of the byte address
//   legal   out 1  access may be forwarded to memory
// ---------------------------------------------------------------------------
module mem_align_chk
    import mem_arb_pkg::*;
(
    input  logic       we,
    input  logic [2:0] func3,
    input  logic [1:0] addr_lo,
    output logic       legal
);

    // Bytes are always aligned; halves need an even address, words a
    // multiple of four. The unsigned variants only make sense for loads,
    // and the remaining func3 codes are not memory widths at all.
    always_comb begin
        legal = 1'b0;
        case (func3)
            F3_B:    legal = 1'b1;
            F3_BU:   legal = ~we;
            F3_H:    legal = ~addr_lo[0];
            F3_HU:   legal = ~we & ~addr_lo[0];
            F3_W:    legal = (addr_lo == 2'b00);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single data-memory port between instruction fetch and the
// load/store unit. One grant per cycle, data has priority, but fetch wins a
// conflict once it has lost STARVE_MAX times in a row. Misaligned or
// illegal-width data accesses are granted but never reach memory; they are
// answered with a one-cycle d_err pulse instead.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   if_req/if_addr -> if_gnt            fetch request / same-cycle grant
//   if_rvalid/if_rdata                  fetch word, cycle after grant
//   d_req/d_we/d_addr/d_func3/d_wdata   data request
//   d_gnt                               data grant, same cycle
//   d_rvalid/d_rdata/d_err              load data or error, cycle after grant
//   m_re/m_we/m_addr/m_func3/m_wdata    memory request
//   m_rdata                             memory read data (registered addr)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_func3,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_func3,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    resp_t      resp_q;
    resp_t      resp_d;
    logic       d_legal;
    logic       fetch_wins;

    // Fetch words are always word aligned, so the low address bits are
    // dropped on purpose.
    logic [1:0] unused_if_addr_lo;
    assign unused_if_addr_lo = if_addr[1:0];

    mem_align_chk u_align_chk (
        .we      (d_we),
        .func3   (d_func3),
        .addr_lo (d_addr[1:0]),
        .legal   (d_legal)
    );

    // Grant selection and memory request steering. Grants are gated with
    // rst_n so nothing can reach memory while reset is held, even though
    // the requesters may still be asserting. The response owner for the
    // next cycle is decided here from the same grant.
    always_comb begin
        fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_LIM));
        if_gnt     = rst_n && fetch_wins;
        d_gnt      = rst_n && d_req && !fetch_wins;

        m_re       = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_func3    = '0;
        m_wdata    = '0;
        resp_d     = RESP_NONE;

        if (if_gnt) begin
            m_re    = 1'b1;
            m_func3 = F3_W;
            m_addr  = {if_addr[ADDR_W-1:2], 2'b00};
            resp_d  = RESP_IF;
        end else if (d_gnt) begin
            m_addr  = d_addr;
            m_func3 = d_func3;
            m_wdata = d_wdata;
            if (d_legal) begin
                m_re   = ~d_we;
                m_we   = d_we;
                resp_d = d_we ? RESP_NONE : RESP_D;
            end else begin
                resp_d = RESP_ERR;
            end
        end
    end

    // Consecutive-loss counter for fetch. It only counts cycles where fetch
    // was actually asking, saturates at the limit so fetch keeps winning
    // until it is served, and clears the moment fetch is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt) begin
            starve_cnt <= 4'd0;
        end else if (if_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Response owner register. Reset drops any response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= RESP_NONE;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Return path: memory data is routed to whoever owns this cycle's
    // response and is forced to zero for everyone else.
    always_comb begin
        if_rvalid = (resp_q == RESP_IF);
        d_rvalid  = (resp_q == RESP_D);
        d_err     = (resp_q == RESP_ERR);
        if_rdata  = if_rvalid ? m_rdata : 32'd0;
        d_rdata   = d_rvalid  ? m_rdata : 32'd0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small byte-addressable memory
// model attached to the m_* port (address registered on m_re, data read
// combinationally from the registered address, stores committed at the edge).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 12;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_func3;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              m_re;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_func3;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    int n_cmp;
    int n_bad;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_func3   (d_func3),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .m_re      (m_re),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_func3   (m_func3),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 1024 words, byte lanes written per func3.
    logic [31:0] mem_words [0:1023];
    logic [9:0]  rd_idx_q;
    logic [1:0]  rd_off_q;
    logic [2:0]  rd_f3_q;
    logic [31:0] rd_shift;

    always @(posedge clk) begin
        if (m_re) begin
            rd_idx_q <= m_addr[11:2];
            rd_off_q <= m_addr[1:0];
            rd_f3_q  <= m_func3;
        end
        if (m_we) begin
            case (m_func3)
                3'b000:  mem_words[m_addr[11:2]][{m_addr[1:0], 3'b000} +: 8] <= m_wdata[7:0];
                3'b001:  mem_words[m_addr[11:2]][{m_addr[1], 4'b0000} +: 16] <= m_wdata[15:0];
                default: mem_words[m_addr[11:2]] <= m_wdata;
            endcase
        end
    end

    always_comb begin
        rd_shift = mem_words[rd_idx_q] >> {rd_off_q, 3'b000};
        case (rd_f3_q)
            3'b000:  m_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  m_rdata = {24'd0, rd_shift[7:0]};
            3'b001:  m_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  m_rdata = {16'd0, rd_shift[15:0]};
            default: m_rdata = mem_words[rd_idx_q];
        endcase
    end

    // Reset with every requester active: grants must stay gated.
    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_if_gnt got=%0h want=0", if_gnt); end
        n_cmp++; if (d_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_d_gnt got=%0h want=0", d_gnt); end
        n_cmp++; if (m_re !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_m_re got=%0h want=0", m_re); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_m_we got=%0h want=0", m_we); end
        n_cmp++; if (m_addr !== 12'h000) begin n_bad++; $display("[TB] FAIL rst_m_addr got=%0h want=0", m_addr); end
        n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_if_rvalid got=%0h want=0", if_rvalid); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_d_rvalid got=%0h want=0", d_rvalid); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_d_err got=%0h want=0", d_err); end
        n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_bad++; $display("[TB] FAIL rst_starve got=%0d want=0", dut.starve_cnt); end
        if_req = 1'b0;
        d_req  = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_rel_if_rvalid got=%0h want=0", if_rvalid); end
    endtask

    // Fetch alone from a non-aligned address.
    task automatic test_fetch();
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 12'h103;
        #1;
        n_cmp++; if (if_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL fetch_if_gnt got=%0h want=1", if_gnt); end
        n_cmp++; if (d_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_d_gnt got=%0h want=0", d_gnt); end
        n_cmp++; if (m_re !== 1'b1) begin n_bad++; $display("[TB] FAIL fetch_m_re got=%0h want=1", m_re); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_m_we got=%0h want=0", m_we); end
        n_cmp++; if (m_addr !== 12'h100) begin n_bad++; $display("[TB] FAIL fetch_m_addr got=%0h want=100", m_addr); end
        n_cmp++; if (m_func3 !== 3'b010) begin n_bad++; $display("[TB] FAIL fetch_m_func3 got=%0h want=2", m_func3); end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        n_cmp++; if (if_rvalid !== 1'b1) begin n_bad++; $display("[TB] FAIL fetch_if_rvalid got=%0h want=1", if_rvalid); end
        n_cmp++; if (if_rdata !== 32'hCAFEF00D) begin n_bad++; $display("[TB] FAIL fetch_if_rdata got=%08h want=cafef00d", if_rdata); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_d_rvalid got=%0h want=0", d_rvalid); end
        @(negedge clk);
        #1;
        n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_idle_rvalid got=%0h want=0", if_rvalid); end
        n_cmp++; if (if_rdata !== 32'd0) begin n_bad++; $display("[TB] FAIL fetch_idle_rdata got=%08h want=0", if_rdata); end
    endtask

    // SW then LW to the same address in consecutive cycles.
    task automatic test_back_to_back();
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_func3 = 3'b010;
        d_addr  = 12'h040;
        d_wdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_if_gnt got=%0h want=0", if_gnt); end
        n_cmp++; if (m_we !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_m_we got=%0h want=1", m_we); end
        n_cmp++; if (m_re !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_m_re got=%0h want=0", m_re); end
        n_cmp++; if (m_addr !== 12'h040) begin n_bad++; $display("[TB] FAIL sw_m_addr got=%0h want=40", m_addr); end
        n_cmp++; if (m_wdata !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL sw_m_wdata got=%08h want=deadbeef", m_wdata); end
        n_cmp++; if (m_func3 !== 3'b010) begin n_bad++; $display("[TB] FAIL sw_m_func3 got=%0h want=2", m_func3); end
        @(negedge clk);
        d_we = 1'b0;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL lw_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (m_re !== 1'b1) begin n_bad++; $display("[TB] FAIL lw_m_re got=%0h want=1", m_re); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_m_we got=%0h want=0", m_we); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_no_rvalid got=%0h want=0", d_rvalid); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        n_cmp++; if (d_rvalid !== 1'b1) begin n_bad++; $display("[TB] FAIL lw_d_rvalid got=%0h want=1", d_rvalid); end
        n_cmp++; if (d_rdata !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL lw_d_rdata got=%08h want=deadbeef", d_rdata); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_d_err got=%0h want=0", d_err); end
        @(negedge clk);
        #1;
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_idle_rvalid got=%0h want=0", d_rvalid); end
        n_cmp++; if (d_rdata !== 32'd0) begin n_bad++; $display("[TB] FAIL lw_idle_rdata got=%08h want=0", d_rdata); end
    endtask

    // Both sides requesting every cycle: expect D,D,D,D,IF repeating.
    task automatic test_starvation();
        logic exp_if;
        logic prev_if;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 12'h100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_func3 = 3'b010;
        d_addr  = 12'h040;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_if = ((i % 5) == 4);
            n_cmp++; if (if_gnt !== exp_if) begin n_bad++; $display("[TB] FAIL starve_if_gnt[%0d] got=%0h want=%0h", i, if_gnt, exp_if); end
            n_cmp++; if (d_gnt !== !exp_if) begin n_bad++; $display("[TB] FAIL starve_d_gnt[%0d] got=%0h want=%0h", i, d_gnt, !exp_if); end
            n_cmp++; if (dut.starve_cnt !== 4'(i % 5)) begin n_bad++; $display("[TB] FAIL starve_cnt[%0d] got=%0d want=%0d", i, dut.starve_cnt, i % 5); end
            if (i > 0) begin
                prev_if = (((i - 1) % 5) == 4);
                n_cmp++; if (if_rvalid !== prev_if) begin n_bad++; $display("[TB] FAIL starve_if_rvalid[%0d] got=%0h want=%0h", i, if_rvalid, prev_if); end
                n_cmp++; if (d_rvalid !== !prev_if) begin n_bad++; $display("[TB] FAIL starve_d_rvalid[%0d] got=%0h want=%0h", i, d_rvalid, !prev_if); end
                n_cmp++; if (d_rdata !== (prev_if ? 32'd0 : 32'hDEADBEEF)) begin n_bad++; $display("[TB] FAIL starve_d_rdata[%0d] got=%08h", i, d_rdata); end
            end
        end
        @(negedge clk);
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        n_cmp++; if (if_rvalid !== 1'b1) begin n_bad++; $display("[TB] FAIL starve_last_if_rvalid got=%0h want=1", if_rvalid); end
        n_cmp++; if (if_rdata !== 32'hCAFEF00D) begin n_bad++; $display("[TB] FAIL starve_last_if_rdata got=%08h want=cafef00d", if_rdata); end
        n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_bad++; $display("[TB] FAIL starve_last_cnt got=%0d want=0", dut.starve_cnt); end
    endtask

    // Misaligned LH, LW and SW: granted, never reach memory, d_err follows.
    task automatic test_misaligned();
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_func3 = 3'b001;
        d_addr  = 12'h041;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL lh_mis_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (m_re !== 1'b0) begin n_bad++; $display("[TB] FAIL lh_mis_m_re got=%0h want=0", m_re); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("[TB] FAIL lh_mis_m_we got=%0h want=0", m_we); end
        @(negedge clk);
        d_func3 = 3'b010;
        d_addr  = 12'h042;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL lw_mis_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (m_re !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_mis_m_re got=%0h want=0", m_re); end
        n_cmp++; if (d_err !== 1'b1) begin n_bad++; $display("[TB] FAIL lh_mis_d_err got=%0h want=1", d_err); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL lh_mis_rvalid got=%0h want=0", d_rvalid); end
        @(negedge clk);
        d_we    = 1'b1;
        d_wdata = 32'h11111111;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_mis_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_mis_m_we got=%0h want=0", m_we); end
        n_cmp++; if (d_err !== 1'b1) begin n_bad++; $display("[TB] FAIL lw_mis_d_err got=%0h want=1", d_err); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_mis_rvalid got=%0h want=0", d_rvalid); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        n_cmp++; if (d_err !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_mis_d_err got=%0h want=1", d_err); end
        @(negedge clk);
        #1;
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("[TB] FAIL mis_err_clear got=%0h want=0", d_err); end
        n_cmp++; if (mem_words[16] !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL mis_mem got=%08h want=deadbeef", mem_words[16]); end
    endtask

    // Store with a load-only width, then a legal SB, then an undefined func3.
    task automatic test_store_func3();
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_func3 = 3'b100;
        d_addr  = 12'h040;
        d_wdata = 32'h12345678;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL sbu_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("[TB] FAIL sbu_m_we got=%0h want=0", m_we); end
        n_cmp++; if (m_re !== 1'b0) begin n_bad++; $display("[TB] FAIL sbu_m_re got=%0h want=0", m_re); end
        @(negedge clk);
        d_func3 = 3'b000;
        d_addr  = 12'h043;
        d_wdata = 32'h000000AA;
        #1;
        n_cmp++; if (m_we !== 1'b1) begin n_bad++; $display("[TB] FAIL sb_m_we got=%0h want=1", m_we); end
        n_cmp++; if (m_func3 !== 3'b000) begin n_bad++; $display("[TB] FAIL sb_m_func3 got=%0h want=0", m_func3); end
        n_cmp++; if (m_addr !== 12'h043) begin n_bad++; $display("[TB] FAIL sb_m_addr got=%0h want=43", m_addr); end
        n_cmp++; if (d_err !== 1'b1) begin n_bad++; $display("[TB] FAIL sbu_d_err got=%0h want=1", d_err); end
        @(negedge clk);
        d_we    = 1'b0;
        d_func3 = 3'b011;
        d_addr  = 12'h040;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL f3bad_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (m_re !== 1'b0) begin n_bad++; $display("[TB] FAIL f3bad_m_re got=%0h want=0", m_re); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("[TB] FAIL sb_d_err got=%0h want=0", d_err); end
        n_cmp++; if (mem_words[16] !== 32'hAAADBEEF) begin n_bad++; $display("[TB] FAIL sb_mem got=%08h want=aaadbeef", mem_words[16]); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        n_cmp++; if (d_err !== 1'b1) begin n_bad++; $display("[TB] FAIL f3bad_d_err got=%0h want=1", d_err); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL f3bad_rvalid got=%0h want=0", d_rvalid); end
        @(negedge clk);
        #1;
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("[TB] FAIL f3bad_err_clear got=%0h want=0", d_err); end
    endtask

    // Reset pulse between a granted LW and its response.
    task automatic test_reset_mid();
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 12'h100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_func3 = 3'b010;
        d_addr  = 12'h040;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_d_gnt0 got=%0h want=1", d_gnt); end
        @(negedge clk);
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_d_gnt1 got=%0h want=1", d_gnt); end
        n_cmp++; if (dut.starve_cnt !== 4'd1) begin n_bad++; $display("[TB] FAIL rmid_cnt_pre got=%0d want=1", dut.starve_cnt); end
        n_cmp++; if (d_rvalid !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_rvalid_pre got=%0h want=1", d_rvalid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_rvalid got=%0h want=0", d_rvalid); end
        n_cmp++; if (d_rdata !== 32'd0) begin n_bad++; $display("[TB] FAIL rmid_rdata got=%08h want=0", d_rdata); end
        n_cmp++; if (d_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_d_gnt got=%0h want=0", d_gnt); end
        n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_if_gnt got=%0h want=0", if_gnt); end
        n_cmp++; if (m_re !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_m_re got=%0h want=0", m_re); end
        n_cmp++; if (m_addr !== 12'h000) begin n_bad++; $display("[TB] FAIL rmid_m_addr got=%0h want=0", m_addr); end
        n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_bad++; $display("[TB] FAIL rmid_cnt got=%0d want=0", dut.starve_cnt); end
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_post_rvalid got=%0h want=0", d_rvalid); end
        n_cmp++; if (d_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_post_err got=%0h want=0", d_err); end
        n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_post_if_rvalid got=%0h want=0", if_rvalid); end
        @(negedge clk);
        d_req = 1'b1;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_new_d_gnt got=%0h want=1", d_gnt); end
        n_cmp++; if (m_re !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_new_m_re got=%0h want=1", m_re); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        n_cmp++; if (d_rvalid !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_new_rvalid got=%0h want=1", d_rvalid); end
        n_cmp++; if (d_rdata !== 32'hAAADBEEF) begin n_bad++; $display("[TB] FAIL rmid_new_rdata got=%08h want=aaadbeef", d_rdata); end
    endtask

    // Sequence of scenarios; starts in reset with both requesters active.
    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rd_idx_q = '0;
        rd_off_q = '0;
        rd_f3_q  = 3'b010;
        for (int k = 0; k < 1024; k++) mem_words[k] = 32'd0;
        mem_words[12'h100 >> 2] = 32'hCAFEF00D;
        rst_n   = 1'b0;
        if_req  = 1'b1;
        if_addr = 12'h104;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 12'h040;
        d_func3 = 3'b010;
        d_wdata = 32'h55555555;

        test_reset();
        test_fetch();
        test_back_to_back();
        test_starvation();
        test_misaligned();
        test_store_func3();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a run that never reaches the summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

endmodule
